// File: rtl/sam_pkg.sv
// rtl/sam_pkg.sv - shared opcodes, FSM states and default widths for sam_cmd_mem
package sam_pkg;

    localparam int SAM_DATA_W = 16;
    localparam int SAM_ADDR_W = 10;
    localparam int SAM_IN_W   = 32;
    localparam int SAM_OUT_W  = 32;

    // Opcode occupies the top SAM_OPC_W bits of the command word.
    localparam int SAM_OPC_W  = 2;

    typedef enum logic [SAM_OPC_W-1:0] {
        OP_NOP        = 2'b00,
        OP_WRITE      = 2'b01,
        OP_READ       = 2'b10,
        OP_WRITE_NEXT = 2'b11
    } sam_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_READ = 1'b1
    } sam_state_e;

    function automatic int sam_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sam_spram.sv
// rtl/sam_spram.sv - single-port RAM with registered read data, contents never reset
module sam_spram
    import sam_pkg::*;
#(
    parameter int DATA_W = SAM_DATA_W,
    parameter int ADDR_W = SAM_ADDR_W
) (
    input  logic              clk,
    input  logic              i_en,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);
    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we) begin
                r_mem[i_addr] <= i_wdata;
            end else begin
                r_rdata <= r_mem[i_addr];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/sam_cmd_mem.sv
// rtl/sam_cmd_mem.sv - command-driven RAM: writes, auto-increment writes and streamed burst reads
module sam_cmd_mem
    import sam_pkg::*;
#(
    parameter int DATA_W = SAM_DATA_W,
    parameter int ADDR_W = SAM_ADDR_W,
    parameter int IN_W   = SAM_IN_W,
    parameter int OUT_W  = SAM_OUT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_last,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy
);
    if (IN_W < SAM_OPC_W + sam_max(2*ADDR_W, ADDR_W+DATA_W)) begin : g_chk_in_w
        $error("sam_cmd_mem: IN_W too narrow for opcode and fields");
    end
    if (OUT_W < DATA_W) begin : g_chk_out_w
        $error("sam_cmd_mem: OUT_W narrower than DATA_W");
    end

    sam_state_e        r_state;
    sam_state_e        w_state_next;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [ADDR_W:0]   r_remaining;
    logic              r_inflight;
    logic              r_inflight_last;
    logic [DATA_W-1:0] r_buf_data [2];
    logic [1:0]        r_buf_last;
    logic              r_head;
    logic [1:0]        r_count;

    sam_op_e           w_op;
    logic              w_accept;
    logic              w_pop;
    logic              w_room;
    logic [1:0]        w_occ;
    logic              w_tail;
    logic [ADDR_W-1:0] w_waddr;
    logic [ADDR_W-1:0] w_start;
    logic [ADDR_W-1:0] w_end;
    logic [ADDR_W-1:0] w_span;
    logic [DATA_W-1:0] w_wdata;
    logic              w_ram_en;
    logic              w_ram_we;
    logic [ADDR_W-1:0] w_ram_addr;
    logic [DATA_W-1:0] w_ram_rdata;
    logic              w_issue;
    logic              w_issue_last;
    logic              w_load_burst;
    logic              w_unused;

    assign w_op     = sam_op_e'(in_data[IN_W-1 -: SAM_OPC_W]);
    assign w_waddr  = in_data[ADDR_W+DATA_W-1:DATA_W];
    assign w_wdata  = in_data[DATA_W-1:0];
    assign w_start  = in_data[2*ADDR_W-1:ADDR_W];
    assign w_end    = in_data[ADDR_W-1:0];
    assign w_span   = w_end - w_start;
    assign w_unused = ^{in_last, in_data};

    assign in_ready = (r_state == ST_IDLE) && !rst;
    assign w_accept = in_valid && in_ready;

    // Credit counts the slot freed by this cycle's pop so a full-rate stream never bubbles.
    assign out_valid = (r_count != 2'd0);
    assign w_pop     = out_valid && out_ready;
    assign w_occ     = r_count - {1'b0, w_pop};
    assign w_room    = ({1'b0, w_occ} + {2'b00, r_inflight}) < 3'd2;
    assign w_tail    = r_head ^ r_count[0];

    assign out_last = out_valid && r_buf_last[r_head];
    assign busy     = (r_state != ST_IDLE) || (r_count != 2'd0);

    always_comb begin
        out_data = '0;
        out_data[DATA_W-1:0] = r_buf_data[r_head];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // The first read of a burst is issued in the accept cycle to meet the two-cycle latency.
    always_comb begin
        w_state_next = r_state;
        w_ram_en     = 1'b0;
        w_ram_we     = 1'b0;
        w_ram_addr   = r_rd_addr;
        w_issue      = 1'b0;
        w_issue_last = 1'b0;
        w_load_burst = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    case (w_op)
                        OP_WRITE: begin
                            w_ram_en   = 1'b1;
                            w_ram_we   = 1'b1;
                            w_ram_addr = w_waddr;
                        end
                        OP_WRITE_NEXT: begin
                            w_ram_en   = 1'b1;
                            w_ram_we   = 1'b1;
                            w_ram_addr = r_wr_ptr;
                        end
                        OP_READ: begin
                            w_ram_en     = 1'b1;
                            w_ram_addr   = w_start;
                            w_issue      = 1'b1;
                            w_issue_last = (w_span == '0);
                            w_load_burst = 1'b1;
                            w_state_next = ST_READ;
                        end
                        default: begin
                        end
                    endcase
                end
            end
            ST_READ: begin
                if ((r_remaining != '0) && w_room) begin
                    w_ram_en     = 1'b1;
                    w_issue      = 1'b1;
                    w_issue_last = (r_remaining == (ADDR_W+1)'(1));
                end
                if (w_pop && out_last) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
        end else if (w_accept && (w_op == OP_WRITE)) begin
            r_wr_ptr <= w_waddr + 1'b1;
        end else if (w_accept && (w_op == OP_WRITE_NEXT)) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
        end
    end

    // r_remaining counts reads still to issue after the one going out this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_addr   <= '0;
            r_remaining <= '0;
        end else if (w_load_burst) begin
            r_rd_addr   <= w_start + 1'b1;
            r_remaining <= {1'b0, w_span};
        end else if (w_issue) begin
            r_rd_addr   <= r_rd_addr + 1'b1;
            r_remaining <= r_remaining - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue_last;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf_data[0] <= '0;
            r_buf_data[1] <= '0;
            r_buf_last    <= '0;
            r_head        <= 1'b0;
            r_count       <= '0;
        end else begin
            if (r_inflight) begin
                r_buf_data[w_tail] <= w_ram_rdata;
                r_buf_last[w_tail] <= r_inflight_last;
            end
            r_head  <= r_head ^ w_pop;
            r_count <= r_count + {1'b0, r_inflight} - {1'b0, w_pop};
        end
    end

    sam_spram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .i_en    (w_ram_en),
        .i_we    (w_ram_we),
        .i_addr  (w_ram_addr),
        .i_wdata (w_wdata),
        .o_rdata (w_ram_rdata)
    );

endmodule

// File: tb/tb_sam_cmd_mem.sv
// tb/tb_sam_cmd_mem.sv - randomized bench for sam_cmd_mem against an array-and-pointer reference model
module tb_sam_cmd_mem;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_last = 1'b0;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_last;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_mem [1024];
    int          m_ptr = 0;

    sam_cmd_mem #(
        .DATA_W (16),
        .ADDR_W (10),
        .IN_W   (32),
        .OUT_W  (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [31:0] cmd);
        in_data  = cmd;
        in_valid = 1'b1;
        in_last  = 1'($urandom);
        @(negedge clk);
        check("cmd_ready", in_ready, 1'b1);
        next_cycle();
        in_valid = 1'b0;
    endtask

    task automatic cmd_write(input logic [9:0] a, input logic [15:0] d);
        send_cmd({2'b01, 4'($urandom), a, d});
        m_mem[a] = d;
        m_ptr    = (int'(a) + 1) % 1024;
    endtask

    task automatic cmd_write_next(input logic [15:0] d);
        send_cmd({2'b11, 14'($urandom), d});
        m_mem[m_ptr] = d;
        m_ptr        = (m_ptr + 1) % 1024;
    endtask

    task automatic cmd_nop();
        send_cmd({2'b00, 30'($urandom)});
    endtask

    // mode 0: out_ready held high; 1: random out_ready; 2: random out_ready plus stray commands
    task automatic do_read(input logic [9:0] s, input logic [9:0] e, input int mode);
        int          n;
        int          idx;
        int          cyc;
        int          a;
        logic        held;
        logic [31:0] held_d;
        logic        held_l;
        n         = ((int'(e) - int'(s) + 1024) % 1024) + 1;
        in_data   = {2'b10, 10'($urandom), s, e};
        in_valid  = 1'b1;
        out_ready = (mode == 0) ? 1'b1 : 1'($urandom);
        @(negedge clk);
        check("rd_accept_ready", in_ready, 1'b1);
        next_cycle();
        in_valid = 1'b0;
        idx  = 0;
        cyc  = 0;
        held = 1'b0;
        held_d = '0;
        held_l = 1'b0;
        while (idx < n && cyc < 4 * n + 20) begin
            cyc++;
            out_ready = (mode == 0) ? 1'b1 : 1'($urandom);
            if (mode == 2) begin
                in_valid = 1'($urandom);
                in_data  = $urandom;
            end
            @(negedge clk);
            check("rd_in_ready_low", in_ready, 1'b0);
            if (held) begin
                check("stall_valid", out_valid, 1'b1);
                check("stall_data", out_data, held_d);
                check("stall_last", out_last, held_l);
            end
            if (out_valid && out_ready) begin
                a = (int'(s) + idx) % 1024;
                check("rd_data", out_data, {16'h0000, m_mem[a]});
                check("rd_last", out_last, (idx == n - 1));
                if (mode == 0) check("rd_cycle", cyc, idx + 2);
                idx++;
            end
            held   = out_valid && !out_ready;
            held_d = out_data;
            held_l = out_last;
            next_cycle();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("rd_word_count", idx, n);
        @(negedge clk);
        check("rd_done_ready", in_ready, 1'b1);
        check("rd_done_busy", busy, 1'b0);
        check("rd_done_valid", out_valid, 1'b0);
        next_cycle();
    endtask

    task automatic abort_test();
        int idx;
        int cyc;
        int seen;
        in_data   = {2'b10, 10'd0, 10'd0, 10'd9};
        in_valid  = 1'b1;
        out_ready = 1'b1;
        next_cycle();
        in_valid = 1'b0;
        idx = 0;
        cyc = 0;
        while (idx < 3 && cyc < 40) begin
            cyc++;
            @(negedge clk);
            if (out_valid && out_ready) begin
                check("ab_data", out_data, {16'h0000, m_mem[idx]});
                idx++;
            end
            next_cycle();
        end
        check("ab_words_before", idx, 3);
        rst       = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        check("ab_ready_in_rst", in_ready, 1'b0);
        next_cycle();
        rst       = 1'b0;
        out_ready = 1'b1;
        m_ptr     = 0;
        @(negedge clk);
        check("ab_valid", out_valid, 1'b0);
        check("ab_last", out_last, 1'b0);
        check("ab_data_zero", out_data, 32'h0);
        check("ab_busy", busy, 1'b0);
        next_cycle();
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) seen++;
            next_cycle();
        end
        check("ab_no_more_words", seen, 0);
        do_read(10'd0, 10'd2, 0);
    endtask

    initial begin
        logic [9:0] s;
        rst = 1'b1;
        next_cycle();
        next_cycle();
        @(negedge clk);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_last", out_last, 1'b0);
        check("rst_out_data", out_data, 32'h0);
        check("rst_busy", busy, 1'b0);
        next_cycle();
        rst = 1'b0;

        // write pointer starts at 0 out of reset
        cmd_write_next(16'hBEEF);
        do_read(10'd0, 10'd0, 0);

        cmd_write(10'd0, 16'($urandom));
        repeat (1023) cmd_write_next(16'($urandom));
        check("fill_ptr_wrapped", m_ptr, 0);

        cmd_write(10'd5, 16'hABCD);
        do_read(10'd5, 10'd5, 0);

        cmd_write(10'h3FE, 16'd1);
        cmd_write_next(16'd2);
        cmd_write_next(16'd3);
        do_read(10'h3FE, 10'h000, 0);

        do_read(10'd0, 10'd15, 0);
        do_read(10'd0, 10'd7, 1);

        repeat (4) cmd_nop();
        do_read(10'd20, 10'd40, 2);
        do_read(10'd0, 10'd63, 1);

        repeat (30) begin
            case ($urandom % 4)
                0: cmd_nop();
                1: cmd_write(10'($urandom), 16'($urandom));
                2: begin
                    s = 10'($urandom);
                    do_read(s, s + 10'($urandom % 24), int'($urandom % 3));
                end
                default: cmd_write_next(16'($urandom));
            endcase
        end

        do_read(10'd7, 10'd6, 0);

        abort_test();
        cmd_write_next(16'h5A5A);
        do_read(10'd0, 10'd1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
